// File: rtl/ws2812b_pkg.sv
// Shared types and constants for the WS2812B frame scheduler: FSM states,
// register addresses and default 64 MHz timing.
package ws2812b_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    HIGH,
    LOW,
    LATCH
  } state_e;

  localparam logic [3:0] ADDR_CTRL   = 4'hC;
  localparam logic [3:0] ADDR_LEN    = 4'hD;
  localparam logic [3:0] ADDR_STATUS = 4'hF;

  localparam int DEF_NUM_PIXELS = 4;
  localparam int DEF_T0H        = 26;
  localparam int DEF_T1H        = 51;
  localparam int DEF_BIT        = 80;
  localparam int DEF_LATCH      = 3840;

  // The 4-bit address map leaves room for four pixels (0x0-0xB).
  localparam int MAX_PIX_BYTES  = 12;

endpackage

// File: rtl/ws2812b_bit_encoder.sv
// Generates one WS2812B bit waveform per start pulse: high for T0H/T1H cycles,
// low for the rest of BIT_CYCLES; bit_done marks the final cycle of the period.
module ws2812b_bit_encoder
  import ws2812b_pkg::*;
#(
  parameter int T0H_CYCLES = DEF_T0H,
  parameter int T1H_CYCLES = DEF_T1H,
  parameter int BIT_CYCLES = DEF_BIT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  input  logic bit_val,
  output logic dout,
  output logic bit_done
);

  localparam int CW = $clog2(BIT_CYCLES);
  localparam logic [CW-1:0] T0H_W  = CW'(T0H_CYCLES);
  localparam logic [CW-1:0] T1H_W  = CW'(T1H_CYCLES);
  localparam logic [CW-1:0] LAST_W = CW'(BIT_CYCLES - 1);

  logic          active_q, active_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] high_q, high_d;
  logic          dout_q, dout_d;
  logic [CW-1:0] cnt_inc;

  always_comb begin
    active_d = active_q;
    cnt_d    = cnt_q;
    high_d   = high_q;
    dout_d   = dout_q;
    cnt_inc  = cnt_q + 1'b1;
    bit_done = active_q && (cnt_q == LAST_W);
    // A start in the last cycle of a period chains the next bit seamlessly.
    if (start) begin
      active_d = 1'b1;
      cnt_d    = '0;
      high_d   = bit_val ? T1H_W : T0H_W;
      dout_d   = 1'b1;
    end else if (active_q) begin
      if (bit_done) begin
        active_d = 1'b0;
        cnt_d    = '0;
        dout_d   = 1'b0;
      end else begin
        cnt_d  = cnt_inc;
        dout_d = (cnt_inc < high_q);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      active_q <= 1'b0;
      cnt_q    <= '0;
      high_q   <= '0;
      dout_q   <= 1'b0;
    end else begin
      active_q <= active_d;
      cnt_q    <= cnt_d;
      high_q   <= high_d;
      dout_q   <= dout_d;
    end
  end

  assign dout = dout_q;

endmodule

// File: rtl/ws2812b_frame_scheduler.sv
// WS2812B frame scheduler: pixel buffer and register file, frame FSM that
// streams G,R,B bytes MSB first through the bit encoder, then holds the latch.
module ws2812b_frame_scheduler
  import ws2812b_pkg::*;
#(
  parameter int NUM_PIXELS   = DEF_NUM_PIXELS,
  parameter int T0H_CYCLES   = DEF_T0H,
  parameter int T1H_CYCLES   = DEF_T1H,
  parameter int BIT_CYCLES   = DEF_BIT,
  parameter int LATCH_CYCLES = DEF_LATCH
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] address,
  input  logic       data_write,
  input  logic [7:0] data_in,
  output logic [7:0] data_out,
  output logic       dout,
  output logic       busy,
  output logic       frame_done
);

  localparam int PIX_BYTES = (3 * NUM_PIXELS > MAX_PIX_BYTES) ? MAX_PIX_BYTES : 3 * NUM_PIXELS;
  localparam logic [4:0] PIX_BYTES_W = 5'(PIX_BYTES);
  localparam logic [2:0] NPIX_W      = 3'(PIX_BYTES / 3);
  localparam int LW = $clog2(LATCH_CYCLES + 1);
  localparam logic [LW-1:0] LATCH_LAST = LW'(LATCH_CYCLES - 1);

  state_e          state_q, state_d;
  logic [7:0]      pix_q [16];
  logic [7:0]      pix_d [16];
  logic [2:0]      len_q, len_d;
  logic            done_q, done_d;
  logic            frame_done_q, frame_done_d;
  logic [7:0]      shift_q, shift_d;
  logic [2:0]      bitcnt_q, bitcnt_d;
  logic [3:0]      idx_q, idx_d;
  logic [3:0]      last_q, last_d;
  logic [LW-1:0]   latch_q, latch_d;

  logic            start_req;
  logic            pix_sel;
  logic [2:0]      len_eff;
  logic [3:0]      idx_next;
  logic [7:0]      next_byte;
  logic            enc_start, enc_bit, enc_dout, enc_bit_done;

  assign start_req = data_write && (address == ADDR_CTRL) && data_in[0];
  assign pix_sel   = ({1'b0, address} < PIX_BYTES_W);
  assign len_eff   = ((len_q == 3'd0) || (len_q > NPIX_W)) ? NPIX_W : len_q;
  assign busy      = (state_q != IDLE);

  always_comb begin
    pix_d  = pix_q;
    len_d  = len_q;
    done_d = done_q;
    if (data_write && pix_sel) pix_d[address] = data_in;
    if (data_write && (address == ADDR_LEN)) len_d = data_in[2:0];
    if (data_write && (address == ADDR_STATUS)) done_d = 1'b0;
    if (frame_done_q) done_d = 1'b1;
  end

  always_comb begin
    state_d      = state_q;
    shift_d      = shift_q;
    bitcnt_d     = bitcnt_q;
    idx_d        = idx_q;
    last_d       = last_q;
    latch_d      = latch_q;
    frame_done_d = 1'b0;
    enc_start    = 1'b0;
    enc_bit      = 1'b0;
    idx_next     = idx_q + 4'd1;
    next_byte    = pix_q[idx_next];
    case (state_q)
      IDLE: begin
        if (start_req) begin
          state_d = LOAD;
          idx_d   = 4'd0;
          last_d  = {len_eff, 1'b0} + {1'b0, len_eff} - 4'd1;
        end
      end
      LOAD: begin
        enc_start = 1'b1;
        enc_bit   = pix_q[idx_q][7];
        shift_d   = pix_q[idx_q];
        bitcnt_d  = 3'd7;
        state_d   = HIGH;
      end
      HIGH, LOW: begin
        if ((state_q == HIGH) && !enc_dout) state_d = LOW;
        // Next byte is fetched straight from the buffer in the last cycle,
        // so byte boundaries keep the exact bit period.
        if (enc_bit_done) begin
          if (bitcnt_q != 3'd0) begin
            enc_start = 1'b1;
            enc_bit   = shift_q[6];
            shift_d   = {shift_q[6:0], 1'b0};
            bitcnt_d  = bitcnt_q - 3'd1;
            state_d   = HIGH;
          end else if (idx_q != last_q) begin
            enc_start = 1'b1;
            enc_bit   = next_byte[7];
            shift_d   = next_byte;
            bitcnt_d  = 3'd7;
            idx_d     = idx_next;
            state_d   = HIGH;
          end else begin
            latch_d = '0;
            state_d = LATCH;
          end
        end
      end
      LATCH: begin
        if (latch_q == LATCH_LAST) begin
          latch_d      = '0;
          frame_done_d = 1'b1;
          state_d      = IDLE;
        end else begin
          latch_d = latch_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      for (int i = 0; i < 16; i++) pix_q[i] <= 8'h00;
      len_q        <= NPIX_W;
      done_q       <= 1'b0;
      frame_done_q <= 1'b0;
      shift_q      <= 8'h00;
      bitcnt_q     <= 3'd0;
      idx_q        <= 4'd0;
      last_q       <= 4'd0;
      latch_q      <= '0;
    end else begin
      state_q      <= state_d;
      pix_q        <= pix_d;
      len_q        <= len_d;
      done_q       <= done_d;
      frame_done_q <= frame_done_d;
      shift_q      <= shift_d;
      bitcnt_q     <= bitcnt_d;
      idx_q        <= idx_d;
      last_q       <= last_d;
      latch_q      <= latch_d;
    end
  end

  always_comb begin
    data_out = 8'h00;
    if (pix_sel) begin
      data_out = pix_q[address];
    end else begin
      case (address)
        ADDR_LEN:    data_out = {5'b0, len_q};
        ADDR_STATUS: data_out = {6'b0, done_q, busy};
        default:     data_out = 8'h00;
      endcase
    end
  end

  assign frame_done = frame_done_q;

  ws2812b_bit_encoder #(
    .T0H_CYCLES (T0H_CYCLES),
    .T1H_CYCLES (T1H_CYCLES),
    .BIT_CYCLES (BIT_CYCLES)
  ) u_enc (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (enc_start),
    .bit_val  (enc_bit),
    .dout     (enc_dout),
    .bit_done (enc_bit_done)
  );

  assign dout = enc_dout;

endmodule
